// File: rtl/arithmetic_pkg.sv
// Shared arithmetic constants: FSM state encodings and zero data word
// used by the shared-unit arbiters.
package arithmetic_pkg;

    localparam int STATE_WIDTH = 1;
    localparam logic [STATE_WIDTH-1:0] STATE_IDLE = 1'b0;
    localparam logic [STATE_WIDTH-1:0] STATE_WAIT = 1'b1;

    localparam logic [63:0] ZERO_DATA = 64'h0;

endpackage

// File: rtl/model_round_robin_picker.sv
// Combinational round-robin picker: returns the first pending index at or
// after ptr, scanning upward with wrap-around.
module model_round_robin_picker #(
    parameter int REQUESTERS = 4,
    parameter int INDEX_SIZE = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] pending,
    input  logic [INDEX_SIZE-1:0] ptr,
    output logic [INDEX_SIZE-1:0] winner,
    output logic                  valid
);

    logic [INDEX_SIZE-1:0] scan_index;

    // Scan from farthest to nearest so the nearest pending index wins.
    always_comb begin
        winner     = '0;
        valid      = 1'b0;
        scan_index = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            scan_index = INDEX_SIZE'((int'(ptr) + k) % REQUESTERS);
            if (pending[scan_index]) begin
                winner = scan_index;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/model_scalar_tanh_arbiter.sv
// Round-robin arbiter sharing one scalar tanh unit among several clients,
// with a watchdog that turns a hung unit into an overflow-flagged result.
module model_scalar_tanh_arbiter
    import arithmetic_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4,
    parameter int REQUESTERS   = 4,
    parameter int TIMEOUT      = 8
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [REQUESTERS-1:0]           REQ_START,
    input  logic [REQUESTERS*DATA_SIZE-1:0] REQ_DATA_IN,
    output logic [REQUESTERS-1:0]           REQ_READY,
    output logic [DATA_SIZE-1:0]            REQ_DATA_OUT,
    output logic                            REQ_OVERFLOW_OUT,
    output logic [REQUESTERS-1:0]           GRANT_OUT,
    output logic                            BUSY_OUT,
    output logic                            TANH_START,
    output logic [DATA_SIZE-1:0]            TANH_DATA_IN,
    input  logic                            TANH_READY,
    input  logic [DATA_SIZE-1:0]            TANH_DATA_OUT,
    input  logic                            TANH_OVERFLOW_IN
);

    localparam int INDEX_SIZE = $clog2(REQUESTERS);

    logic [STATE_WIDTH-1:0]  state;
    logic [REQUESTERS-1:0]   pending;
    logic [REQUESTERS-1:0]   accept;
    logic [REQUESTERS-1:0]   clear;
    logic [DATA_SIZE-1:0]    hold [REQUESTERS];
    logic [INDEX_SIZE-1:0]   ptr;
    logic [INDEX_SIZE-1:0]   owner;
    logic [INDEX_SIZE-1:0]   winner;
    logic                    winner_valid;
    logic [CONTROL_SIZE-1:0] watchdog;
    logic                    timed_out;
    logic                    done;

    model_round_robin_picker #(
        .REQUESTERS(REQUESTERS),
        .INDEX_SIZE(INDEX_SIZE)
    ) picker (
        .pending(pending),
        .ptr    (ptr),
        .winner (winner),
        .valid  (winner_valid)
    );

    assign timed_out = (state == STATE_WAIT) && !TANH_READY
                       && (watchdog == CONTROL_SIZE'(TIMEOUT - 1));
    assign done      = (state == STATE_WAIT) && (TANH_READY || timed_out);
    assign clear     = done ? (REQUESTERS'(1) << owner) : '0;
    // A new request on the owner's delivery edge is accepted: set beats clear.
    assign accept    = REQ_START & (~pending | clear);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending <= '0;
            for (int i = 0; i < REQUESTERS; i++) begin
                hold[i] <= '0;
            end
        end else begin
            pending <= (pending & ~clear) | accept;
            for (int i = 0; i < REQUESTERS; i++) begin
                if (accept[i]) begin
                    hold[i] <= REQ_DATA_IN[i*DATA_SIZE +: DATA_SIZE];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state            <= STATE_IDLE;
            ptr              <= '0;
            owner            <= '0;
            watchdog         <= '0;
            REQ_READY        <= '0;
            REQ_DATA_OUT     <= '0;
            REQ_OVERFLOW_OUT <= 1'b0;
            GRANT_OUT        <= '0;
            BUSY_OUT         <= 1'b0;
            TANH_START       <= 1'b0;
            TANH_DATA_IN     <= '0;
        end else begin
            REQ_READY  <= '0;
            TANH_START <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (winner_valid) begin
                        TANH_START   <= 1'b1;
                        TANH_DATA_IN <= hold[winner];
                        GRANT_OUT    <= REQUESTERS'(1) << winner;
                        BUSY_OUT     <= 1'b1;
                        owner        <= winner;
                        watchdog     <= '0;
                        state        <= STATE_WAIT;
                    end
                end
                STATE_WAIT: begin
                    if (done) begin
                        REQ_READY        <= clear;
                        REQ_DATA_OUT     <= timed_out ? ZERO_DATA[DATA_SIZE-1:0] : TANH_DATA_OUT;
                        REQ_OVERFLOW_OUT <= timed_out ? 1'b1 : TANH_OVERFLOW_IN;
                        ptr              <= INDEX_SIZE'((int'(owner) + 1) % REQUESTERS);
                        GRANT_OUT        <= '0;
                        BUSY_OUT         <= 1'b0;
                        state            <= STATE_IDLE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                default: state <= STATE_IDLE;
            endcase
        end
    end

endmodule

// File: doc/model_scalar_tanh_arbiter.md
# model_scalar_tanh_arbiter

Round-robin arbiter that shares one scalar tanh unit (`model_scalar_tanh_function`) among `REQUESTERS` independent clients. Each client posts one IEEE-754 double operand with a START pulse. The arbiter latches the operand, grants the unit fairly, waits for the unit's READY pulse, and returns the result to the owning client with a one-cycle READY pulse. A watchdog converts a hung unit into an overflow-flagged result. It sits between the vector/matrix function controllers and the single shared tanh datapath.

## Interface
- `DATA_SIZE`, 64: operand/result width (IEEE-754 double bits).
- `CONTROL_SIZE`, 4: watchdog counter width.
- `REQUESTERS`, 4: number of clients, ≥2.
- `TIMEOUT`, 8: max WAIT cycles before forced completion; 4 ≤ TIMEOUT < 2**CONTROL_SIZE.

Ports:
- `CLK`  in  1  clock. Reset `RST`, asynchronous, active-high; clock `CLK`.
- `RST`  in  1  asynchronous active-high reset.
- `REQ_START`  in  REQUESTERS  per-client request pulse.
- `REQ_DATA_IN`  in  REQUESTERS*DATA_SIZE  client i operand at `[i*DATA_SIZE +: DATA_SIZE]`.
- `REQ_READY`  out  REQUESTERS  one-hot one-cycle completion pulse.
- `REQ_DATA_OUT`  out  DATA_SIZE  result, valid while `REQ_READY` is high.
- `REQ_OVERFLOW_OUT`  out  1  overflow/timeout flag, valid with `REQ_READY`.
- `GRANT_OUT`  out  REQUESTERS  one-hot owner of the unit; 0 when idle.
- `BUSY_OUT`  out  1  high in WAIT.
- `TANH_START`  out  1  one-cycle start pulse to the unit.
- `TANH_DATA_IN`  out  DATA_SIZE  operand to the unit.
- `TANH_READY`  in  1  unit completion pulse.
- `TANH_DATA_OUT`  in  DATA_SIZE  unit result.
- `TANH_OVERFLOW_IN`  in  1  unit overflow.

## Operation
- Per-client state: `pending[i]` bit and `hold[i]` operand register.
- Accepting a request: `REQ_START[i]` is sampled when `pending[i]` is 0. It sets `pending[i]` and loads `hold[i]`.
- Duplicate requests: `REQ_START[i]` while `pending[i]` is 1 (queued or in service) is ignored, and `hold[i]` is unchanged.
- FSM states: IDLE and WAIT.
- IDLE with any pending request:
  - Winner = first pending index at or after `ptr`, scanning upward with wrap.
  - Register `TANH_START`=1, `TANH_DATA_IN`=`hold[w]`, `GRANT_OUT`=onehot(w), `BUSY_OUT`=1.
  - Clear the watchdog and go to WAIT.
- WAIT:
  - `TANH_START` returns to 0 after one cycle.
  - The watchdog increments each cycle in which `TANH_READY` is 0.
- WAIT, normal completion (`TANH_READY`=1):
  - `REQ_DATA_OUT`=`TANH_DATA_OUT`, `REQ_OVERFLOW_OUT`=`TANH_OVERFLOW_IN`, `REQ_READY[w]`=1 for one cycle.
  - Clear `pending[w]`, set `ptr`=(w+1) mod REQUESTERS, clear `GRANT_OUT`/`BUSY_OUT`, go to IDLE.
- WAIT, timeout (watchdog = TIMEOUT-1 and `TANH_READY`=0):
  - Same as normal completion, except `REQ_DATA_OUT`=0 and `REQ_OVERFLOW_OUT`=1.
- `TANH_READY` outside WAIT is ignored.
- Simultaneous clear and new request: if `REQ_START[w]` arrives on the delivery edge, set wins. The new request is accepted and `hold[w]` is reloaded. Because `ptr` has advanced past w, other pending clients are served first.
- Reset (any time, including mid-WAIT):
  - All outputs 0: `REQ_READY`, `REQ_DATA_OUT`, `REQ_OVERFLOW_OUT`, `GRANT_OUT`, `BUSY_OUT`, `TANH_START`, `TANH_DATA_IN`.
  - `pending`=0, `hold`=0, `ptr`=0, watchdog=0, state IDLE.
  - In-flight work is dropped with no `REQ_READY`.

## Timing
Cycle numbers below are edges, with edge 0 = `REQ_START` sampled.
- Single request, idle unit:
  - Edge 0: `pending` set.
  - Edge 1: `TANH_START` issued.
  - Edge 2: unit samples START.
  - Edge 3: unit asserts READY.
  - Edge 4: `REQ_READY` asserted. Latency 4 cycles.
- Back-to-back service period: 4 cycles (deliver at edge n, issue at n+1).
- Timeout delivery: at edge 1+TIMEOUT (edge 9 by default).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package (`arithmetic_pkg`) holds `ZERO_DATA` and the IDLE/WAIT state constants; add them there if missing.
- Natural sub-module: `model_round_robin_picker`, a combinational picker that takes the pending vector and `ptr` and returns the winner index and a valid flag. It is reused by other shared-unit arbiters.
- The scalar tanh unit is instantiated outside this block, at the level that owns the datapath.

## Test plan
1. Single request:
   - Stimulus: `REQ_DATA_IN[0]`=bits(0.5), `REQ_START[0]` pulse.
   - Required response: `REQ_READY`=0001 at edge 4, `REQ_DATA_OUT`=bits(0.46211715726), overflow 0, `GRANT_OUT` back to 0.
2. Simultaneous requests:
   - Stimulus: all 4 clients pulse `REQ_START` at edge 0 with `ptr`=0.
   - Required response: `REQ_READY` to clients 0,1,2,3 at edges 4,8,12,16 with the matching tanh results.
3. Fairness:
   - Stimulus: client 0 re-requests on its delivery edge while client 2 is pending.
   - Required response: service order 0, 2, 0.
4. Duplicate request:
   - Stimulus: client 1 sends bits(1.0), then bits(2.0) while pending.
   - Required response: exactly one `REQ_READY[1]`, with result tanh(1.0)=0.76159415595.
5. Timeout:
   - Stimulus: stub unit never asserts READY.
   - Required response: `REQ_READY` at edge 9, data 0, `REQ_OVERFLOW_OUT`=1. The next pending client is granted at edge 10.
6. Reset mid-operation:
   - Stimulus: assert `RST` during WAIT, then the stub emits a late `TANH_READY`.
   - Required response: all outputs 0, no `REQ_READY`, the stale READY is ignored, and a new request completes with 4-cycle latency.
